fpa_arbiter: RTL and testbench

- Shares one pipelined floating-point adder (fpa, fixed latency, no valid/stall signals) between NREQ requesters.
- Round-robin arbitration grants one operand pair per cycle.
- A tag pipeline tracks the requester ID of each in-flight pair; results are queued in an output FIFO with requester ID attached.
- Credit accounting ensures in-flight results never overflow the FIFO, so the un-stallable adder is never blocked.

---
 rtl/fpa_arbiter_pkg.sv | 27 ++
 rtl/fpa_arbiter_if.sv | 31 +++
 rtl/fpa_res_fifo.sv | 73 +++++++
 rtl/fpa_arbiter.sv | 142 ++++++++++++++
 tb/tb_fpa_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpa_arbiter_pkg.sv
// Shared constants and helpers for the floating-point adder arbiter.
//   FP_W        : operand / result width of the shared adder
//   DEF_*       : default parameter values for the arbiter slice
//   entry_w()   : width of one result FIFO entry (result + requester ID)
//   cnt_w()     : width of a counter that must hold 0..n inclusive
//   ptr_w()     : width of a pointer that indexes 0..n-1
package fpa_arbiter_pkg;

    localparam int FP_W        = 32;
    localparam int DEF_NREQ    = 4;
    localparam int DEF_IDW     = 2;
    localparam int DEF_LATENCY = 7;
    localparam int DEF_DEPTH   = 8;

    function automatic int entry_w(input int idw);
        return FP_W + idw;
    endfunction

    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int ptr_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fpa_arbiter_if.sv
// Requester / consumer bundle of the adder arbiter.
//   req_valid/req_a/req_b/req_ready : per-requester operand handshake,
//                                     requester i packed at [FP_W*i +: FP_W]
//   res_valid/res_ready/res_c/res_id : result stream with requester ID
// master = requesters + consumer side, slave = arbiter side.
interface fpa_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    import fpa_arbiter_pkg::*;

    logic [NREQ-1:0]      req_valid;
    logic [FP_W*NREQ-1:0] req_a;
    logic [FP_W*NREQ-1:0] req_b;
    logic [NREQ-1:0]      req_ready;
    logic                 res_valid;
    logic                 res_ready;
    logic [FP_W-1:0]      res_c;
    logic [IDW-1:0]       res_id;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_c, res_id
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_c, res_id
    );

endinterface

// File: rtl/fpa_res_fifo.sv
// Synchronous first-word fall-through FIFO for adder results.
//   clk, rst : clock, synchronous active-high reset
//   push/din : write an entry (must not be issued while full)
//   pop      : consume the head entry; ignored when empty
//   dout     : head entry, read combinationally from storage
//   count    : number of stored entries (0..DEPTH)
//   empty    : no entries stored
module fpa_res_fifo
    import fpa_arbiter_pkg::*;
#(
    parameter int WIDTH = 34,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = ptr_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty  = (count == '0);
    assign do_pop = pop && !empty;
    assign dout   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // The credit scheme upstream makes a push into a full FIFO impossible.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !do_pop && (count == CW'(DEPTH))));
        end
    end

endmodule

// File: rtl/fpa_arbiter.sv
// Shares one un-stallable pipelined FP adder between NREQ requesters.
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : request handshake in, result stream out
//   fpa_a, fpa_b : registered operands to the adder
//   fpa_c        : adder result, LATENCY cycles after its operands
//   busy         : operations in flight or results still queued
// Round-robin picks one request per cycle; a tag pipeline follows each
// operand pair through the adder and pushes the result with its ID into a
// FWFT FIFO.  Issue is only allowed while in-flight ops plus queued results
// leave room in the FIFO, so the adder output never has to wait.
module fpa_arbiter
    import fpa_arbiter_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int IDW     = DEF_IDW,
    parameter int LATENCY = DEF_LATENCY,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    fpa_arbiter_if.slave    bus,
    output logic [FP_W-1:0] fpa_a,
    output logic [FP_W-1:0] fpa_b,
    input  logic [FP_W-1:0] fpa_c,
    output logic            busy
);

    localparam int EW = entry_w(IDW);
    localparam int CW = $clog2(DEPTH + 1);
    // Stage 0 rides alongside the operands on fpa_a/fpa_b; stage LATENCY is
    // the one that lines up with the matching result on fpa_c.
    localparam int TAG_N = LATENCY + 1;
    localparam int IW    = cnt_w(TAG_N);

    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  winner;
    logic            found;
    logic [FP_W-1:0] win_a;
    logic [FP_W-1:0] win_b;
    logic            issue_ok;
    logic            accept;
    logic            retire;
    logic            pop;
    logic [31:0]     outstanding;

    logic [TAG_N-1:0] tag_v;
    logic [IDW-1:0]   tag_id [TAG_N];
    logic [IW-1:0]    inflight;

    logic [CW-1:0]    fifo_count;
    logic             fifo_empty;
    logic [EW-1:0]    fifo_dout;

    // Round-robin search from rr_ptr, wrapping modulo NREQ.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && bus.req_valid[IDW'(idx)]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == IDW'(i)) begin
                win_a = bus.req_a[FP_W*i +: FP_W];
                win_b = bus.req_b[FP_W*i +: FP_W];
            end
        end
    end

    // Credit counts queued results as occupied until the pop edge, so a
    // freed slot is usable one cycle after the pop.
    assign outstanding   = 32'(inflight) + 32'(fifo_count);
    assign issue_ok      = (outstanding < 32'(DEPTH));
    assign accept        = found && issue_ok;
    assign bus.req_ready = accept ? (NREQ'(1) << winner) : '0;

    assign retire = tag_v[TAG_N-1];
    assign pop    = !fifo_empty && bus.res_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            fpa_a    <= '0;
            fpa_b    <= '0;
            rr_ptr   <= '0;
            inflight <= '0;
            tag_v    <= '0;
            for (int s = 0; s < TAG_N; s++) begin
                tag_id[s] <= '0;
            end
        end else begin
            if (accept) begin
                fpa_a  <= win_a;
                fpa_b  <= win_b;
                rr_ptr <= (int'(winner) == NREQ - 1) ? '0 : winner + IDW'(1);
            end
            tag_v[0]  <= accept;
            tag_id[0] <= winner;
            for (int s = 1; s < TAG_N; s++) begin
                tag_v[s]  <= tag_v[s-1];
                tag_id[s] <= tag_id[s-1];
            end
            case ({accept, retire})
                2'b10:   inflight <= inflight + IW'(1);
                2'b01:   inflight <= inflight - IW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    fpa_res_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (retire),
        .din   ({fpa_c, tag_id[TAG_N-1]}),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    assign bus.res_valid = !fifo_empty;
    assign bus.res_c     = fifo_dout[EW-1:IDW];
    assign bus.res_id    = fifo_dout[IDW-1:0];
    assign busy          = (inflight != '0) || (fifo_count != '0);

endmodule

// File: tb/tb_fpa_arbiter.sv
module tb_fpa_arbiter;
    import fpa_arbiter_pkg::*;

    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int LAT   = 7;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fpa_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    logic [31:0] fpa_a, fpa_b, fpa_c;
    logic        busy;

    fpa_arbiter #(
        .NREQ(NREQ), .IDW(IDW), .LATENCY(LAT), .DEPTH(DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .fpa_a (fpa_a),
        .fpa_b (fpa_b),
        .fpa_c (fpa_c),
        .busy  (busy)
    );

    // ---------------- single-precision helpers (normal numbers only) ----
    function automatic logic [63:0] sp2dp(input logic [31:0] x);
        if (x[30:23] == 8'd0) return {x[31], 63'd0};
        return {x[31], 11'(int'(x[30:23]) + 896), x[22:0], 29'd0};
    endfunction

    function automatic logic [31:0] dp2sp(input logic [63:0] d);
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        return {d[63], 8'(int'(d[62:52]) - 896), d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        real ra, rb;
        ra = $bitstoreal(sp2dp(a));
        rb = $bitstoreal(sp2dp(b));
        return dp2sp($realtobits(ra + rb));
    endfunction

    function automatic logic [31:0] int2sp(input int n);
        real r;
        r = n;
        return dp2sp($realtobits(r));
    endfunction

    // ---------------- adder model: LAT register stages -----------------
    logic [31:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= fadd(fpa_a, fpa_b);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign fpa_c = pipe[LAT-1];

    // ---------------- requesters ----------------
    logic [31:0]     ra [NREQ];
    logic [31:0]     rb [NREQ];
    logic [NREQ-1:0] rv;

    always_comb begin
        bus.req_a = '0;
        bus.req_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[32*i +: 32] = ra[i];
            bus.req_b[32*i +: 32] = rb[i];
        end
    end
    assign bus.req_valid = rv;

    // ---------------- reference model ----------------
    // Outstanding = accepted operations whose result has not been popped.
    // Each accepted op becomes visible at the output LAT+2 cycles later.
    typedef struct {
        logic [31:0] c;
        int          id;
        int          avail;
    } exp_t;

    exp_t q[$];
    int   outstanding = 0;
    int   rr          = 0;
    int   cyc         = 0;
    int   n_tests     = 0;
    int   n_fail      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_winner();
        if (outstanding >= DEPTH) return -1;
        for (int k = 0; k < NREQ; k++) begin
            if (rv[(rr + k) % NREQ]) return (rr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int avail_cnt();
        int n;
        n = 0;
        foreach (q[i]) if (q[i].avail <= cyc) n++;
        return n;
    endfunction

    // One clock cycle: compare at the falling edge, then advance the model.
    task automatic step();
        int              w;
        logic [NREQ-1:0] er;
        logic            erv;
        logic            epop;
        exp_t            e;
        @(negedge clk);
        w    = -1;
        epop = 1'b0;
        if (!rst) begin
            w  = model_winner();
            er = (w >= 0) ? (NREQ'(1) << w) : '0;
            check("req_ready", 64'(bus.req_ready), 64'(er));
            erv = (q.size() > 0) && (q[0].avail <= cyc);
            check("res_valid", 64'(bus.res_valid), 64'(erv));
            if (erv) begin
                check("res_c", 64'(bus.res_c), 64'(q[0].c));
                check("res_id", 64'(bus.res_id), 64'(q[0].id));
            end
            check("busy", 64'(busy), 64'(outstanding != 0));
            epop = erv && bus.res_ready;
        end
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            outstanding = 0;
            rr          = 0;
        end else begin
            if (epop) begin
                void'(q.pop_front());
                outstanding--;
            end
            if (w >= 0) begin
                e.c     = fadd(ra[w], rb[w]);
                e.id    = w;
                e.avail = cyc + LAT + 2;
                q.push_back(e);
                rr    = (w + 1) % NREQ;
                rv[w] = 1'b0;
                outstanding++;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rv  = '0;
        bus.res_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic set_ops_const(input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = a;
            rb[i] = b;
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [NREQ-1:0] valid;
        logic [NREQ-1:0] ready;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int c0, seen, nacc, got, issued;

        vecs[0] = '{4'b0000, 4'b0000};
        vecs[1] = '{4'b0010, 4'b0010};
        vecs[2] = '{4'b1111, 4'b0100};
        vecs[3] = '{4'b1111, 4'b1000};
        vecs[4] = '{4'b0110, 4'b0010};
        vecs[5] = '{4'b0001, 4'b0001};
        vecs[6] = '{4'b1001, 4'b1000};
        vecs[7] = '{4'b1000, 4'b1000};

        rv = '0;
        bus.res_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = int2sp(i + 1);
            rb[i] = int2sp(10 * (i + 1));
        end

        // Reset state
        do_reset();
        do_reset();
        #1;
        check("rst fpa_a", 64'(fpa_a), 64'd0);
        check("rst fpa_b", 64'(fpa_b), 64'd0);
        check("rst req_ready", 64'(bus.req_ready), 64'd0);
        check("rst res_valid", 64'(bus.res_valid), 64'd0);
        check("rst busy", 64'(busy), 64'd0);

        // Round-robin vectors
        bus.res_ready = 1'b1;
        for (int v = 0; v < 8; v++) begin
            rv = vecs[v].valid;
            #1;
            check("tbl ready", 64'(bus.req_ready), 64'(vecs[v].ready));
            step();
        end
        rv = '0;
        repeat (20) step();

        // Single request 2.0 + 3.0 from requester 1
        do_reset();
        ra[1] = 32'h4000_0000;
        rb[1] = 32'h4040_0000;
        rv = 4'b0010;
        c0 = cyc;
        seen = -1;
        for (int t = 0; t < 30; t++) begin
            step();
            if (bus.res_valid) begin
                seen = cyc;
                break;
            end
        end
        check("single latency", 64'(seen - c0), 64'(LAT + 2));
        check("single res_c", 64'(bus.res_c), 64'h40A0_0000);
        check("single res_id", 64'(bus.res_id), 64'd1);
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        check("single busy after pop", 64'(busy), 64'd0);

        // All requesters continuously valid, grants in rotation
        do_reset();
        set_ops_const(32'h4000_0000, 32'h4000_0000);
        bus.res_ready = 1'b1;
        nacc = 0;
        for (int t = 0; t < 60 && nacc < 12; t++) begin
            rv = '1;
            #1;
            if ((rv & bus.req_ready) != '0) begin
                check("rotation grant", 64'(bus.req_ready), 64'(NREQ'(1) << (nacc % NREQ)));
                nacc++;
            end
            step();
        end
        check("rotation count", 64'(nacc), 64'd12);
        rv = '0;
        repeat (25) step();

        // Credit exhaustion with res_ready low
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = int2sp(i + 1);
            rb[i] = int2sp(100);
        end
        nacc = 0;
        for (int t = 0; t < 20; t++) begin
            rv = '1;
            #1;
            if ((rv & bus.req_ready) != '0) nacc++;
            step();
        end
        check("exhaust accepts", 64'(nacc), 64'(DEPTH));
        #1;
        check("exhaust ready", 64'(bus.req_ready), 64'd0);
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        nacc = 0;
        for (int k = 0; k < 6; k++) begin
            rv = '1;
            #1;
            if (k == 0) check("credit grant", 64'(bus.req_ready), 64'b0001);
            if ((rv & bus.req_ready) != '0) nacc++;
            step();
        end
        check("one accept per pop", 64'(nacc), 64'd1);

        // Only requester 3 valid while credit is exhausted
        rv = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("r3 blocked", 64'(bus.req_ready), 64'd0);
            step();
        end
        check("fpa_a held", 64'(fpa_a), 64'(int2sp(1)));
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        got = 0;
        for (int k = 0; k < 2 && got == 0; k++) begin
            #1;
            if (bus.req_ready == 4'b1000) got = 1;
            step();
        end
        check("r3 grant after pop", 64'(got), 64'd1);
        rv = '0;
        bus.res_ready = 1'b1;
        repeat (30) step();

        // 20 ops through a partially filled FIFO (pointer wrap)
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = int2sp(7 * i + 3);
            rb[i] = int2sp(i + 20);
        end
        issued = 0;
        for (int t = 0; t < 150; t++) begin
            rv = (issued < 20) ? '1 : '0;
            #1;
            if ((rv & bus.req_ready) != '0) issued++;
            if (avail_cnt() >= 3) bus.res_ready = 1'b1;
            step();
        end
        check("wrap issued", 64'(issued), 64'd20);
        check("wrap drained", 64'(bus.res_valid), 64'd0);

        // Reset with 5 operations in flight
        do_reset();
        for (int k = 0; k < 5; k++) begin
            rv = '1;
            step();
        end
        rv = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 2 * LAT; k++) begin
            #1;
            check("post-rst res_valid", 64'(bus.res_valid), 64'd0);
            check("post-rst busy", 64'(busy), 64'd0);
            step();
        end
        rv = 4'b1100;
        #1;
        check("post-rst grant", 64'(bus.req_ready), 64'b0100);
        step();
        rv = '0;
        repeat (15) step();

        // Randomized traffic against the model
        do_reset();
        for (int t = 0; t < 500; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!rv[i] && $urandom_range(0, 1) == 1) begin
                    ra[i] = int2sp(int'($urandom_range(1, 1000)));
                    rb[i] = int2sp(int'($urandom_range(1, 1000)));
                    rv[i] = 1'b1;
                end
            end
            bus.res_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        rv = '0;
        bus.res_ready = 1'b1;
        repeat (30) step();
        #1;
        check("final busy", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
